// File: rtl/hw_timer_pkg.sv
// Shared definitions for hw_timer: register map, CTRL fields, mode codes, FSM states.
// Optional prescaler build is selected with TIMER_PRESCALE_EN.
package hw_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_TIM_IM   = 3;
  localparam int CTRL_DIV_LSB  = 4;
  localparam int CTRL_DIV_MSB  = 11;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Bit of CP0 HWInt[7:2] driven by this timer's IRQ.
  localparam int TIMER_HWINT_IDX = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_t;

endpackage

// File: rtl/hw_timer_prescaler.sv
// 8-bit divider for hw_timer: counts 0..div while running, ticks on the wrap cycle.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module hw_timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       run,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt;

  // >= keeps the divider sane if div is lowered below the current count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (run)
      cnt <= (cnt >= div) ? 8'd0 : cnt + 8'd1;
  end

  assign tick = run && (cnt >= div);

endmodule

// File: rtl/hw_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) raising a level IRQ toward CP0 HWInt.
// Define TIMER_PRESCALE_EN to add the CTRL[11:4] prescaler.
//
// state | meaning
// IDLE  | stopped, COUNT holds, waits for Enable
// LOAD  | COUNT <= PRESET
// CNT   | decrementing COUNT (on prescaler ticks)
// INT   | terminal count reached, flag set; reload or stop
module hw_timer
  import hw_timer_pkg::*;
#(
  parameter int          ADDR_W       = 2,
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              WE,
  input  logic [31:0]       DIn,
  output logic [31:0]       DOut,
  output logic              IRQ
);

  timer_state_t state;
  logic         ctrl_en;
  logic [1:0]   ctrl_mode;
  logic         ctrl_im;
  logic [31:0]  preset;
  logic [31:0]  count;
  logic         irq_flag;
  logic [31:0]  ctrl_word;
  logic         tick;
  logic         wr_ctrl;
  logic         wr_preset;
  logic         unused_din;

  assign wr_ctrl   = WE && (Addr == ADDR_W'(ADDR_CTRL));
  assign wr_preset = WE && (Addr == ADDR_W'(ADDR_PRESET));

`ifdef TIMER_PRESCALE_EN
  logic [7:0] ctrl_div;

  hw_timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_LOAD),
    .run   (state == ST_CNT),
    .div   (ctrl_div),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ctrl_div <= '0;
    else if (wr_ctrl)
      ctrl_div <= DIn[CTRL_DIV_MSB:CTRL_DIV_LSB];
  end

  assign ctrl_word  = {20'd0, ctrl_div, ctrl_im, ctrl_mode, ctrl_en};
  assign unused_din = ^DIn[31:12];
`else
  assign tick       = 1'b1;
  assign ctrl_word  = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
  assign unused_din = ^DIn[31:4];
`endif

  // Later assignments win: a CPU write to CTRL overrides the FSM's Enable clear,
  // and any CTRL/PRESET write (the handler's ack) overrides a same-cycle flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
      preset    <= RESET_PRESET;
      count     <= '0;
      irq_flag  <= 1'b0;
    end else begin
      if (wr_preset)
        preset <= DIn;

      case (state)
        ST_IDLE: begin
          if (ctrl_en)
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_en) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (count == 32'd0) begin
              state    <= ST_INT;
              irq_flag <= 1'b1;
            end else begin
              count <= count - 32'd1;
            end
          end
        end
        ST_INT: begin
          if (ctrl_mode == MODE_RELOAD) begin
            state    <= ST_LOAD;
            irq_flag <= 1'b0;
          end else begin
            state   <= ST_IDLE;
            ctrl_en <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (wr_ctrl) begin
        ctrl_en   <= DIn[CTRL_EN_BIT];
        ctrl_mode <= DIn[CTRL_MODE_MSB:CTRL_MODE_LSB];
        ctrl_im   <= DIn[CTRL_TIM_IM];
      end

      if (wr_ctrl || wr_preset)
        irq_flag <= 1'b0;
    end
  end

  assign IRQ = ctrl_im & irq_flag;

  always_comb begin
    DOut = '0;
    if (Addr == ADDR_W'(ADDR_CTRL))
      DOut = ctrl_word;
    else if (Addr == ADDR_W'(ADDR_PRESET))
      DOut = preset;
    else if (Addr == ADDR_W'(ADDR_COUNT))
      DOut = count;
  end

endmodule

// File: tb/tb_hw_timer.sv
// Self-checking bench for hw_timer: register-access vector table plus timed sequences.
module tb_hw_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  int total;
  int bad;

  hw_timer dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .DIn   (DIn),
    .DOut  (DOut),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    DIn  = d;
    WE   = 1'b1;
    step();
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = DOut;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(name, v, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    chk(name, {31'd0, IRQ}, {31'd0, exp});
  endtask

  initial begin
    int pulses;
    int first;
    int dbl;
    logic prev;
    logic [31:0] ctrl_ff6;

    total = 0;
    bad   = 0;
    reset = 1'b0;
    Addr  = 2'd0;
    WE    = 1'b0;
    DIn   = 32'd0;

`ifdef TIMER_PRESCALE_EN
    ctrl_ff6 = 32'h0000_0FF6;
`else
    ctrl_ff6 = 32'h0000_0006;
`endif

    vecs[0] = '{1'b1, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 2'd0, 32'hFFFF_FFF6, ctrl_ff6};
    vecs[2] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{1'b1, 2'd3, 32'h1234_5678, 32'h0000_0000};
    vecs[4] = '{1'b0, 2'd1, 32'h5555_5555, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{1'b1, 2'd1, 32'h0000_0007, 32'h0000_0007};

    step();
    step();
    chk_reg("rst_ctrl", 2'd0, 32'h0);
    chk_reg("rst_count", 2'd2, 32'h0);
    chk_irq("rst_irq", 1'b0);
    Addr = 2'd0;
    reset = 1'b1;
    step();
    chk_reg("rst_preset", 2'd1, 32'h0);

    // register access table
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v;
      Addr = vecs[i].addr;
      DIn  = vecs[i].din;
      WE   = vecs[i].we;
      step();
      WE   = 1'b0;
      rd(vecs[i].addr, v);
      chk($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // one-shot, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    step();
    for (int k = 2; k <= 5; k++) begin
      step();
      chk_reg($sformatf("oneshot_count_e%0d", k), 2'd2, 32'(5 - k));
      chk_irq("oneshot_irq_low", 1'b0);
    end
    step();
    chk_irq("oneshot_irq_e6", 1'b1);
    step();
    chk_reg("oneshot_ctrl_e7", 2'd0, 32'h8);
    chk_irq("oneshot_irq_e7", 1'b1);
    step();
    step();
    step();
    chk_irq("oneshot_irq_hold", 1'b1);
    wr(2'd0, 32'h8);
    chk_irq("oneshot_ack", 1'b0);

    // auto-reload, PRESET=2
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    pulses = 0;
    first  = -1;
    dbl    = 0;
    prev   = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (IRQ) begin
        pulses++;
        if (first < 0) first = k;
        if (prev) dbl++;
      end
      prev = IRQ;
    end
    chk("reload_pulses", 32'(pulses), 32'd10);
    chk("reload_first", 32'(first), 32'd5);
    chk("reload_wide", 32'(dbl), 32'd0);
    wr(2'd0, 32'h0);
    step();
    step();
    step();

    // IM=0: reaches INT (Enable self-clears) but IRQ stays low
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_irq("mask_irq", 1'b0);
    end
    chk_reg("mask_ctrl", 2'd0, 32'h0);
    chk_reg("mask_count", 2'd2, 32'h0);

    // disable while counting with COUNT=5
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) step();
    wr(2'd0, 32'h8);
    for (int k = 0; k < 5; k++) begin
      chk_reg("disable_count", 2'd2, 32'd5);
      chk_irq("disable_irq", 1'b0);
      step();
    end

    // PRESET write during CNT only affects the next run
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    step();
    step();
    step();
    chk_reg("prew_count_e3", 2'd2, 32'd3);
    wr(2'd1, 32'd1);
    chk_reg("prew_count_e4", 2'd2, 32'd2);
    step();
    step();
    chk_reg("prew_count_e6", 2'd2, 32'd0);
    chk_irq("prew_irq_e6", 1'b0);
    step();
    chk_irq("prew_irq_e7", 1'b1);
    step();
    chk_reg("prew_ctrl_e8", 2'd0, 32'h8);
    wr(2'd0, 32'h9);
    step();
    step();
    chk_reg("prew2_count_e2", 2'd2, 32'd1);
    step();
    chk_reg("prew2_count_e3", 2'd2, 32'd0);
    chk_irq("prew2_irq_e3", 1'b0);
    step();
    chk_irq("prew2_irq_e4", 1'b1);
    step();

    // ack in the same cycle as the flag set: ack wins
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) step();
    chk_irq("race_irq_e4", 1'b0);
    wr(2'd1, 32'd2);
    chk_irq("race_irq_e5", 1'b0);
    step();
    chk_irq("race_irq_e6", 1'b0);
    chk_reg("race_ctrl_e6", 2'd0, 32'h8);

    // PRESET=0 and CTRL write winning over Enable clear in INT
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step();
    step();
    chk_irq("p0_irq_e2", 1'b0);
    step();
    chk_irq("p0_irq_e3", 1'b1);
    wr(2'd0, 32'h9);
    chk_reg("ctrlwin_ctrl_e4", 2'd0, 32'h9);
    chk_irq("ctrlwin_irq_e4", 1'b0);
    step();
    step();
    chk_irq("ctrlwin_irq_e6", 1'b0);
    step();
    chk_irq("ctrlwin_irq_e7", 1'b1);
    step();
    chk_reg("ctrlwin_ctrl_e8", 2'd0, 32'h8);

`ifdef TIMER_PRESCALE_EN
    // DIV=3, PRESET=1: COUNT steps every 4 cycles
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h39);
    chk_reg("psc_ctrl", 2'd0, 32'h39);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k >= 2) chk_reg($sformatf("psc_count_e%0d", k), 2'd2, (k < 6) ? 32'd1 : 32'd0);
      chk_irq($sformatf("psc_irq_e%0d", k), k == 10);
    end
    step();
    chk_reg("psc_ctrl_end", 2'd0, 32'h38);
`endif

    // async reset mid-count
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) step();
    chk_reg("rstmid_count_pre", 2'd2, 32'd7);
    #1 reset = 1'b0;
    chk_reg("rstmid_count", 2'd2, 32'd0);
    chk_reg("rstmid_ctrl", 2'd0, 32'd0);
    chk_reg("rstmid_preset", 2'd1, 32'd0);
    chk_irq("rstmid_irq", 1'b0);
    step();
    reset = 1'b1;
    step();

    // async reset with IRQ high
    wr(2'd0, 32'h9);
    step();
    step();
    step();
    chk_irq("rstirq_pre", 1'b1);
    #1 reset = 1'b0;
    #1;
    chk_irq("rstirq_irq", 1'b0);
    chk_reg("rstirq_ctrl", 2'd0, 32'd0);
    step();
    reset = 1'b1;
    step();
    wr(2'd1, 32'd5);
    for (int k = 0; k < 6; k++) step();
    chk_reg("post_rst_idle_count", 2'd2, 32'd0);
    chk_irq("post_rst_idle_irq", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
